// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encodings and default constants.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    localparam int unsigned STATE_W     = 2;
    localparam int unsigned PTS_W       = 4;
    localparam int unsigned WIN_SCORE   = 9;
    localparam int unsigned CLK_HZ      = 100_000_000;

endpackage

// File: rtl/serve_timer.sv
// Serve delay counter: cleared by load, counts while en, flags the terminal cycle.
module serve_timer #(
    parameter int unsigned SERVE_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(SERVE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && (cnt_q == LAST);

endmodule

// File: rtl/game_fsm.sv
// Pong match controller: idle, serve delay, play and game-over sequencing with point tallies.
module game_fsm
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = pong_pkg::WIN_SCORE,
    parameter int unsigned SERVE_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               score1,
    input  logic               score2,
    output logic [STATE_W-1:0] state,
    output logic               ball_en,
    output logic               ball_hold,
    output logic               clr_score,
    output logic [1:0]         winner,
    output logic [PTS_W-1:0]   p1_pts,
    output logic [PTS_W-1:0]   p2_pts
);

    localparam logic [PTS_W-1:0] WIN_PTS = PTS_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic               start_q;
    logic               ball_en_q, ball_en_d;
    logic               ball_hold_q, ball_hold_d;
    logic               clr_score_q, clr_score_d;
    logic [1:0]         winner_q, winner_d;
    logic [PTS_W-1:0]   p1_q, p1_d;
    logic [PTS_W-1:0]   p2_q, p2_d;

    logic               start_rise;
    logic               tmr_load;
    logic               tmr_done;
    logic [PTS_W-1:0]   p1_nxt;
    logic [PTS_W-1:0]   p2_nxt;

    assign start_rise = start & ~start_q;

    serve_timer #(
        .SERVE_CYCLES (SERVE_CYCLES)
    ) u_serve_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (state_q == ST_SERVE),
        .done  (tmr_done)
    );

    // Next-state, tally and output decode; ball gating follows the next state so it lines up with state.
    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        winner_d    = winner_q;
        clr_score_d = 1'b0;
        tmr_load    = 1'b0;
        p1_nxt      = p1_q + PTS_W'(score1);
        p2_nxt      = p2_q + PTS_W'(score2);

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    tmr_load = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tmr_done) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (score1 || score2) begin
                    p1_d = p1_nxt;
                    p2_d = p2_nxt;
                    if ((p1_nxt == WIN_PTS) || (p2_nxt == WIN_PTS)) begin
                        state_d  = ST_OVER;
                        winner_d = {p2_nxt == WIN_PTS, p1_nxt == WIN_PTS};
                    end else begin
                        state_d  = ST_SERVE;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d     = ST_SERVE;
                    tmr_load    = 1'b1;
                    p1_d        = '0;
                    p2_d        = '0;
                    winner_d    = 2'b00;
                    clr_score_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ball_en_d   = (state_d == ST_PLAY);
        ball_hold_d = ~ball_en_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            ball_en_q   <= 1'b0;
            ball_hold_q <= 1'b1;
            clr_score_q <= 1'b0;
            winner_q    <= 2'b00;
            p1_q        <= '0;
            p2_q        <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            ball_en_q   <= ball_en_d;
            ball_hold_q <= ball_hold_d;
            clr_score_q <= clr_score_d;
            winner_q    <= winner_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
        end
    end

    assign state     = state_q;
    assign ball_en   = ball_en_q;
    assign ball_hold = ball_hold_q;
    assign clr_score = clr_score_q;
    assign winner    = winner_q;
    assign p1_pts    = p1_q;
    assign p2_pts    = p2_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed per-cycle vectors for game_fsm (SERVE_CYCLES=4, WIN_SCORE=3) with a queued scoreboard.
module tb_game_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       score1;
    logic       score2;
    logic [1:0] state;
    logic       ball_en;
    logic       ball_hold;
    logic       clr_score;
    logic [1:0] winner;
    logic [3:0] p1_pts;
    logic [3:0] p2_pts;

    typedef struct {
        int         id;
        logic [1:0] state;
        logic       en;
        logic       hold;
        logic       clr;
        logic [1:0] win;
        logic [3:0] p1;
        logic [3:0] p2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   row    = 0;

    game_fsm #(
        .WIN_SCORE    (3),
        .SERVE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .score1    (score1),
        .score2    (score2),
        .state     (state),
        .ball_en   (ball_en),
        .ball_hold (ball_hold),
        .clr_score (clr_score),
        .winner    (winner),
        .p1_pts    (p1_pts),
        .p2_pts    (p2_pts)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic step(input logic r, input logic st, input logic s1, input logic s2,
                        input logic [1:0] e_st, input logic e_en, input logic e_hold,
                        input logic e_clr, input logic [1:0] e_win,
                        input logic [3:0] e_p1, input logic [3:0] e_p2);
        exp_t e;
        @(negedge clk);
        reset  = r;
        start  = st;
        score1 = s1;
        score2 = s2;
        row++;
        e.id = row; e.state = e_st; e.en = e_en; e.hold = e_hold;
        e.clr = e_clr; e.win = e_win; e.p1 = e_p1; e.p2 = e_p2;
        exp_q.push_back(e);
    endtask

    task automatic serve3(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd0, a, b);
    endtask

    task automatic play1(input logic [3:0] a, input logic [3:0] b);
        step(0, 0, 0, 0, 2'd2, 1, 0, 0, 2'd0, a, b);
    endtask

    // Monitor: compare every registered output set one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (state !== e.state || ball_en !== e.en || ball_hold !== e.hold ||
                    clr_score !== e.clr || winner !== e.win || p1_pts !== e.p1 || p2_pts !== e.p2) begin
                    errors++;
                    $display("FAIL row%0d got st=%b en=%b hold=%b clr=%b win=%b p1=%0d p2=%0d exp st=%b en=%b hold=%b clr=%b win=%b p1=%0d p2=%0d",
                             e.id, state, ball_en, ball_hold, clr_score, winner, p1_pts, p2_pts,
                             e.state, e.en, e.hold, e.clr, e.win, e.p1, e.p2);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; score1 = 1'b0; score2 = 1'b0;

        // Reset and basic serve with ignored pulse/start edges in SERVE and PLAY
        step(1, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(1, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd2, 1, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd2, 1, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd2, 1, 0, 0, 2'd0, 0, 0);

        // Player 1 wins 3-0; a score2 pulse in OVER is dropped
        step(0, 0, 1, 0, 2'd1, 0, 1, 0, 2'd0, 1, 0);
        serve3(1, 0); play1(1, 0);
        step(0, 0, 1, 0, 2'd1, 0, 1, 0, 2'd0, 2, 0);
        serve3(2, 0); play1(2, 0);
        step(0, 0, 1, 0, 2'd3, 0, 1, 0, 2'd1, 3, 0);
        step(0, 0, 0, 1, 2'd3, 0, 1, 0, 2'd1, 3, 0);

        // Rematch with start held high: single clr pulse, no action on reaching PLAY
        step(0, 1, 0, 0, 2'd1, 0, 1, 1, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd2, 1, 0, 0, 2'd0, 0, 0);
        step(0, 1, 0, 0, 2'd2, 1, 0, 0, 2'd0, 0, 0);

        // Build to 2-2, then simultaneous pulses end the game with both winner bits
        step(0, 1, 0, 1, 2'd1, 0, 1, 0, 2'd0, 0, 1);
        serve3(0, 1); play1(0, 1);
        step(0, 0, 0, 1, 2'd1, 0, 1, 0, 2'd0, 0, 2);
        serve3(0, 2); play1(0, 2);
        step(0, 0, 1, 0, 2'd1, 0, 1, 0, 2'd0, 1, 2);
        serve3(1, 2); play1(1, 2);
        step(0, 0, 1, 0, 2'd1, 0, 1, 0, 2'd0, 2, 2);
        serve3(2, 2); play1(2, 2);
        step(0, 0, 1, 1, 2'd3, 0, 1, 0, 2'd3, 3, 3);
        step(0, 0, 0, 0, 2'd3, 0, 1, 0, 2'd3, 3, 3);

        // Rematch, p2 reaches 2 (one SERVE pulse dropped), then reset in the second SERVE cycle
        step(0, 1, 0, 0, 2'd1, 0, 1, 1, 2'd0, 0, 0);
        serve3(0, 0); play1(0, 0);
        step(0, 0, 0, 1, 2'd1, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 1, 2'd1, 0, 1, 0, 2'd0, 0, 1);
        step(0, 0, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 1);
        play1(0, 1);
        step(0, 0, 0, 1, 2'd1, 0, 1, 0, 2'd0, 0, 2);
        step(1, 1, 1, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);

        // Reset mid-PLAY, and a score pulse in IDLE is dropped
        step(0, 1, 0, 0, 2'd1, 0, 1, 0, 2'd0, 0, 0);
        serve3(0, 0); play1(0, 0);
        step(1, 0, 1, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 1, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd0, 0, 1, 0, 2'd0, 0, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
